// File: rtl/uart_pkg.sv
// Shared UART transmit types, frame constants and parity helper.
// Optional even-parity build: define UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } uart_state_e;

  localparam logic        START_BIT        = 1'b0;
  localparam logic        STOP_BIT         = 1'b1;
  localparam logic [2:0]  LAST_DATA_IDX    = 3'd7;
  localparam logic [15:0] MIN_CLKS_PER_BIT = 16'd2;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: registered storage, power-of-two depth, push/pop
// with registered full/empty flags.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_s;
  logic          full_r;
  logic          empty_r;
  logic          push_s;
  logic          pop_s;

  assign push_s  = push_i && !full_r;
  assign pop_s   = pop_i && !empty_r;
  assign data_o  = mem_r[rd_ptr_r];
  assign full_o  = full_r;
  assign empty_o = empty_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (AW + 1)'(1);
      2'b01:   count_s = count_r - (AW + 1)'(1);
      default: count_s = count_r;
    endcase
  end

  // Storage, pointers and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
      full_r  <= (count_s == FULL_CNT);
      empty_r <= (count_s == '0);
    end
  end

endmodule

// File: rtl/uart_tx_prog.sv
// Buffered UART transmitter with run-time bit period (CLKS_PER_BIT).
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_prog
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] CLKS_PER_BIT,
  input  logic        tx_dv_i,
  input  logic [7:0]  tx_byte_i,
  output logic        tx_ready_o,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done
);

  uart_state_e state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] cpb_r, cpb_s;
  logic [15:0] cpb_in_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  data_r, data_s;
  logic        serial_r, serial_s;
  logic        active_r, active_s;
  logic        done_r, done_s;
  logic        bit_end_s;
  logic        pop_s;
  logic        push_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [7:0]  fifo_data_s;

  assign push_s      = tx_dv_i && !fifo_full_s;
  assign tx_ready_o  = !fifo_full_s;
  assign o_Tx_Serial = serial_r;
  assign o_Tx_Active = active_r;
  assign o_Tx_Done   = done_r;
  assign cpb_in_s    = (CLKS_PER_BIT < MIN_CLKS_PER_BIT) ? MIN_CLKS_PER_BIT : CLKS_PER_BIT;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .data_i  (tx_byte_i),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Frame sequencing: bit timing, bit index and FIFO pops.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    cpb_s     = cpb_r;
    idx_s     = idx_r;
    data_s    = data_r;
    pop_s     = 1'b0;
    bit_end_s = (cnt_r == (cpb_r - 16'd1));
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_s = START;
          cnt_s   = 16'd0;
          cpb_s   = cpb_in_s;
          data_s  = fifo_data_s;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          cnt_s   = 16'd0;
          idx_s   = 3'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s = 16'd0;
          if (idx_r == LAST_DATA_IDX) begin
            idx_s = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          cnt_s = 16'd0;
          // Chain the next frame straight out of the stop bit.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_s = START;
            cpb_s   = cpb_in_s;
            data_s  = fifo_data_s;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 16'd0;
      end
    endcase
  end

  // Line outputs decoded from the next state so they register in step with it.
  always_comb begin
    serial_s = STOP_BIT;
    case (state_s)
      IDLE:    serial_s = STOP_BIT;
      START:   serial_s = START_BIT;
      DATA:    serial_s = data_s[idx_s];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_s = even_parity(data_s);
`endif
      STOP:    serial_s = STOP_BIT;
      default: serial_s = STOP_BIT;
    endcase
    active_s = (state_s != IDLE);
    done_s   = (state_s == STOP) && (cnt_s == (cpb_s - 16'd1));
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      cnt_r    <= 16'd0;
      cpb_r    <= MIN_CLKS_PER_BIT;
      idx_r    <= 3'd0;
      data_r   <= 8'h00;
      serial_r <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      cpb_r    <= cpb_s;
      idx_r    <= idx_s;
      data_r   <= data_s;
      serial_r <= serial_s;
      active_r <= active_s;
      done_r   <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_prog.sv
// Randomised and directed bench for uart_tx_prog against a frame-level model.
module tb_uart_tx_prog;

  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpb;
  logic        dv;
  logic [7:0]  tx_byte;
  logic        ready;
  logic        serial;
  logic        active;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;

  // model: accepted bytes waiting, plus the frame currently on the line
  logic [7:0] mq[$];
  int         frame_rem = 0;
  int         frame_len = 0;
  int         m_cpb     = 2;
  logic [10:0] frame_bits;

  uart_tx_prog #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .CLKS_PER_BIT (cpb),
    .tx_dv_i      (dv),
    .tx_byte_i    (tx_byte),
    .tx_ready_o   (ready),
    .o_Tx_Serial  (serial),
    .o_Tx_Active  (active),
    .o_Tx_Done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    m_cpb = (cpb < 16'd2) ? 2 : int'(cpb);
    frame_len = FLEN * m_cpb;
    frame_rem = frame_len;
    frame_bits = '1;
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame_bits[1 + i] = b[i];
    if (FLEN == 11) frame_bits[9] = ^b;
    frame_bits[FLEN - 1] = 1'b1;
  endtask

  task automatic compare_outputs();
    int exp_ser;
    int exp_act;
    int exp_done;
    if (frame_rem > 0) begin
      exp_ser  = int'(frame_bits[(frame_len - frame_rem) / m_cpb]);
      exp_act  = 1;
      exp_done = (frame_rem == 1) ? 1 : 0;
    end else begin
      exp_ser  = 1;
      exp_act  = 0;
      exp_done = 0;
    end
    check_val("serial", int'(serial), exp_ser);
    check_val("active", int'(active), exp_act);
    check_val("done", int'(done), exp_done);
    check_val("ready", int'(ready), (mq.size() < DEPTH) ? 1 : 0);
  endtask

  // one clock: model sees the pre-edge inputs, outputs compared on the falling edge
  task automatic tick();
    int s;
    bit acc;
    bit pop;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      frame_rem = 0;
    end else begin
      s   = mq.size();
      acc = dv && (s < DEPTH);
      pop = (frame_rem <= 1) && (s > 0);
      if (pop) start_frame(mq.pop_front());
      else if (frame_rem > 0) frame_rem--;
      if (acc) mq.push_back(tx_byte);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic push(input logic [7:0] b);
    dv = 1'b1;
    tx_byte = b;
    tick();
    dv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int guard = 0;
    while ((mq.size() > 0 || frame_rem > 0) && guard < 20000) begin
      tick();
      guard++;
    end
    check_val("drain_timeout", mq.size() + frame_rem, 0);
    idle(3);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    mq.delete();
    frame_rem = 0;
    #1;
    compare_outputs();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    dv = 1'b0;
    tx_byte = 8'h00;
    cpb = 16'd4;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // long bit period, single byte
    cpb = 16'h015C;
    push(8'hA5);
    drain();

    // five consecutive pushes from idle, then a push while full is dropped
    cpb = 16'd8;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    push(8'h66);
    idle(5);
    push(8'h77);
    drain();

    // back-to-back extremes with no idle gap
    cpb = 16'd4;
    push(8'h00);
    push(8'hFF);
    drain();

    // reset in the middle of data bit 3 with bytes still queued
    cpb = 16'd4;
    push(8'h5A); push(8'hC3); push(8'h3C);
    guard = 0;
    while (frame_rem > 0 && ((frame_len - frame_rem) / m_cpb) < 4 && guard < 200) begin
      tick();
      guard++;
    end
    pulse_reset();
    idle(30);

    // degenerate bit periods behave as two clocks
    cpb = 16'd1;
    push(8'h07);
    drain();
    cpb = 16'd0;
    push(8'h80);
    drain();

    // random traffic with changing bit period and rare resets
    for (int i = 0; i < 4000; i++) begin
      dv = ($urandom_range(0, 3) == 0);
      tx_byte = 8'($urandom);
      if ($urandom_range(0, 99) == 0) cpb = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 1499) == 0) begin
        dv = 1'b0;
        pulse_reset();
      end else begin
        tick();
      end
    end
    dv = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_prog.md
UART_TX_PROG -- requirements
Module: uart_tx_prog

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16): transmit byte buffer entries.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port CLKS_PER_BIT  input  16  clocks per serial bit.
REQ-005 SHALL have port tx_dv_i  input  1  byte push strobe, one byte per high cycle.
REQ-006 SHALL have port tx_byte_i  input  8  byte to send.
REQ-007 SHALL have port tx_ready_o  output  1  high when the FIFO is not full.
REQ-008 SHALL have port o_Tx_Serial  output  1  serial line, idle high.
REQ-009 SHALL have port o_Tx_Active  output  1  high while a frame is on the line.
REQ-010 SHALL have port o_Tx_Done  output  1  one-cycle pulse per completed frame.

Function
REQ-011 SHALL accept a byte at a rising edge where tx_dv_i=1 and tx_ready_o=1; when tx_ready_o=0, tx_dv_i SHALL be ignored and the byte dropped.
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when the FIFO is non-empty, START->DATA, DATA->PARITY after bit 7 when parity is compiled in, otherwise DATA->STOP; PARITY->STOP; STOP->START when the FIFO is non-empty, otherwise STOP->IDLE.
REQ-013 SHALL pop the FIFO head on the IDLE->START or STOP->START edge; byte accepted at edge N with empty FIFO and FSM idle: o_Tx_Serial low from edge N+1.
REQ-014 SHALL latch CLKS_PER_BIT at each START entry; the value is held for the whole frame; values 0 and 1 SHALL be treated as 2.
REQ-015 SHALL hold each bit for exactly the latched CLKS_PER_BIT cycles, using a 16-bit counter 0..CLKS_PER_BIT-1.
REQ-016 SHALL drive: start bit 0, then data LSB first, optional parity, then stop bit 1.
REQ-017 SHALL start back-to-back frames with no idle gap: next start bit immediately follows the stop-bit period.
REQ-018 SHALL drive o_Tx_Active high in START/DATA/PARITY/STOP and low in IDLE.
REQ-019 SHALL pulse o_Tx_Done for one cycle on the last cycle of each stop bit.
REQ-020 SHALL allow a simultaneous push and pop in the same cycle when not full; occupancy is unchanged.

Reset
REQ-021 SHALL, while rst_ni=0 (including mid-frame), set the FSM to IDLE, empty the FIFO, clear the counters, and drive o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, tx_ready_o=1; no partial frame resumes after release.

Configuration
REQ-022 SHALL, with UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of data bits) after bit 7, giving 11-bit frames.
REQ-023 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and send 10-bit frames.

Structure
REQ-024 SHALL place the FSM state enum, frame-bit constants and the minimum clocks-per-bit constant (2) in shared package uart_pkg.
REQ-025 SHALL implement the buffer as sub-module uart_tx_fifo (parameter DEPTH; push/pop/full/empty; registered storage).

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=16'h015C, push 0xA5, no parity -> low 348 cycles, then 1,0,1,0,0,1,0,1 at 348 cycles each, stop high; o_Tx_Done pulse 3480 cycles after start.
REQ-027 SHALL cover: push 5 bytes in 5 consecutive cycles while idle (DEPTH 4) -> first is popped at once, all 5 sent, tx_ready_o=1 throughout; with line stalled mid-frame, a 6th push when full -> tx_ready_o=0 and byte dropped.
REQ-028 SHALL cover: push 0x00 and 0xFF back-to-back, CLKS_PER_BIT=4 -> second start bit immediately after first stop bit, o_Tx_Active stays high 80 cycles.
REQ-029 SHALL cover: assert rst_ni=0 during DATA bit 3 -> o_Tx_Serial=1 and FIFO empty immediately; after release, line idle until a new push.
REQ-030 SHALL cover: UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1; CLKS_PER_BIT=1 -> 2 cycles per bit.
